// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle processor controller.
//   ctrl_state_t : controller FSM states
//   pc_ms        : next-PC mux select
//   alu_b_ms     : ALU port B select
//   rf_wdat_ms   : register file write-data select
//   dec_t        : opcode/funct classification produced by control_decode
// Optional feature macro used by the top: CTRL_PERF_EN (performance counters).
package multicycle_control_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALTED} ctrl_state_t;

  typedef enum logic [1:0] {PC_NPC, PC_JUMP, PC_JRA, PC_BRANCH} pc_ms;
  typedef enum logic [1:0] {AB_RF, AB_SHAMT, AB_EXT32} alu_b_ms;
  typedef enum logic [1:0] {RFW_ALUO, RFW_RAMDATA, RFW_IMM16, RFW_NPC} rf_wdat_ms;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;  // first of the I-type ALU group
  localparam logic [5:0] OP_LUI   = 6'h0F;  // last of the I-type ALU group
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef struct packed {
    logic      halt;
    logic      ld;
    logic      st;
    logic      j;
    logic      jr;
    logic      jal;
    logic      beq;
    logic      bne;
    logic      rf_write;  // instruction writes the register file in WB
    alu_b_ms   alub;      // ALU B select used in EXEC
    rf_wdat_ms rfw;       // write-data select used in WB
  } dec_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// control_decode: combinational opcode/funct classification.
//   opcode, funct : instruction-register fields
//   dec           : instruction class flags and datapath selects
// Opcodes outside the known set decode with every flag clear, so they flow
// through EXEC into WB without a register write (no-op).
module control_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  logic rtype;

  always_comb begin
    rtype        = (opcode == OP_RTYPE);
    dec          = '0;
    dec.halt     = (opcode == OP_HALT);
    dec.ld       = (opcode == OP_LW);
    dec.st       = (opcode == OP_SW);
    dec.j        = (opcode == OP_J);
    dec.jal      = (opcode == OP_JAL);
    dec.beq      = (opcode == OP_BEQ);
    dec.bne      = (opcode == OP_BNE);
    dec.jr       = rtype && (funct == FN_JR);
    dec.rf_write = (rtype && !dec.jr) || (opcode inside {[OP_ADDI:OP_LUI]}) ||
                   dec.ld || dec.jal;

    if (rtype && (funct == FN_SLL || funct == FN_SRL)) dec.alub = AB_SHAMT;
    else if (rtype || dec.beq || dec.bne)               dec.alub = AB_RF;
    else                                                dec.alub = AB_EXT32;

    if (dec.ld)                  dec.rfw = RFW_RAMDATA;
    else if (opcode == OP_LUI)   dec.rfw = RFW_IMM16;
    else if (dec.jal)            dec.rfw = RFW_NPC;
    else                         dec.rfw = RFW_ALUO;
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing a multicycle processor datapath.
//   CLK, nRST            : clock, asynchronous active-low reset
//   opcode, funct        : instruction-register fields (stable after FETCH)
//   zero                 : ALU zero flag for branch resolution in EXEC
//   imem_ready/dmem_ready: memory access completes this cycle
//   pc_sel/alub_sel/rfw_sel : datapath mux selects
//   pc_en, ir_en, rf_wen : register load strobes
//   imem_ren, dmem_ren, dmem_wen : memory requests
//   halt                 : sticky halted indication
// Optional: CTRL_PERF_EN adds instr_cnt (pc_en pulses) and stall_cnt
// (cycles with a memory request waiting on its ready).
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output pc_ms       pc_sel,
  output alu_b_ms    alub_sel,
  output rf_wdat_ms  rfw_sel,
  output logic       pc_en,
  output logic       ir_en,
  output logic       imem_ren,
  output logic       dmem_ren,
  output logic       dmem_wen,
  output logic       rf_wen,
  output logic       halt
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0] instr_cnt,
  output logic [31:0] stall_cnt
`endif
);

  ctrl_state_t state, state_nxt;
  dec_t        dec;

  control_decode u_dec (
    .opcode (opcode),
    .funct  (funct),
    .dec    (dec)
  );

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= FETCH;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = imem_ready ? DECODE : FETCH;
      DECODE:  state_nxt = dec.halt ? HALTED : EXEC;
      EXEC:
        if (dec.ld || dec.st)                         state_nxt = MEM;
        else if (dec.j || dec.jr || dec.beq || dec.bne) state_nxt = FETCH;
        else                                          state_nxt = WB;
      MEM:     if (dmem_ready) state_nxt = dec.ld ? WB : FETCH;
      WB:      state_nxt = FETCH;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = FETCH;
    endcase
  end

  // Strobes are qualified with nRST so that asserting reset silences them
  // in the same instant, even though state itself resets to FETCH.
  always_comb begin
    pc_sel   = PC_NPC;
    alub_sel = AB_RF;
    rfw_sel  = RFW_ALUO;
    pc_en    = 1'b0;
    ir_en    = 1'b0;
    imem_ren = 1'b0;
    dmem_ren = 1'b0;
    dmem_wen = 1'b0;
    rf_wen   = 1'b0;
    halt     = 1'b0;
    if (nRST) begin
      case (state)
        FETCH: begin
          imem_ren = 1'b1;
          ir_en    = imem_ready;
        end
        EXEC: begin
          alub_sel = dec.alub;
          if (dec.j) begin
            pc_sel = PC_JUMP;
            pc_en  = 1'b1;
          end else if (dec.jr) begin
            pc_sel = PC_JRA;
            pc_en  = 1'b1;
          end else if (dec.beq || dec.bne) begin
            pc_sel = ((dec.beq && zero) || (dec.bne && !zero)) ? PC_BRANCH : PC_NPC;
            pc_en  = 1'b1;
          end
        end
        MEM: begin
          dmem_ren = dec.ld;
          dmem_wen = dec.st;
          pc_en    = dec.st && dmem_ready;
        end
        WB: begin
          rfw_sel = dec.rfw;
          rf_wen  = dec.rf_write;
          pc_en   = 1'b1;
          pc_sel  = dec.jal ? PC_JUMP : PC_NPC;
        end
        HALTED:  halt = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CTRL_PERF_EN
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pc_en) instr_cnt <= instr_cnt + 32'd1;
      if ((imem_ren && !imem_ready) || ((dmem_ren || dmem_wen) && !dmem_ready))
        stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control. The driver walks a
// behavioural per-instruction phase model, pushing the expected output word
// of every cycle; a negedge monitor pops and compares against the DUT.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  pc_ms       pc_sel;
  alu_b_ms    alub_sel;
  rf_wdat_ms  rfw_sel;
  logic       pc_en, ir_en, imem_ren, dmem_ren, dmem_wen, rf_wen, halt;
`ifdef CTRL_PERF_EN
  logic [31:0] instr_cnt, stall_cnt;
  int unsigned exp_instr = 0, exp_stall = 0;
`endif

  multicycle_control dut (
    .CLK(CLK), .nRST(nRST), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_sel(pc_sel), .alub_sel(alub_sel), .rfw_sel(rfw_sel),
    .pc_en(pc_en), .ir_en(ir_en), .imem_ren(imem_ren), .dmem_ren(dmem_ren),
    .dmem_wen(dmem_wen), .rf_wen(rf_wen), .halt(halt)
`ifdef CTRL_PERF_EN
    , .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    pc_ms      pc_sel;
    alu_b_ms   alub_sel;
    rf_wdat_ms rfw_sel;
    logic      pc_en, ir_en, imem_ren, dmem_ren, dmem_wen, rf_wen, halt;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    errors = 0, checks = 0, cyc = 0;

  logic [12:0] act_v;
  assign act_v = {pc_sel, alub_sel, rfw_sel, pc_en, ir_en, imem_ren,
                  dmem_ren, dmem_wen, rf_wen, halt};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: one expected output word per cycle, compared mid-cycle.
  always @(negedge CLK) begin
    cyc++;
    if (exp_q.size() > 0) begin
      obs_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk($sformatf("%s@%0d", t, cyc), {19'd0, act_v}, {19'd0, 13'(e)});
    end
  end

  function automatic obs_t idle();
    obs_t e;
    e = '0;
    e.pc_sel = PC_NPC; e.alub_sel = AB_RF; e.rfw_sel = RFW_ALUO;
    return e;
  endfunction

  // Drive one cycle's inputs, record its expectation, advance to posedge+1.
  task automatic drive(input logic ir, input logic dr, input obs_t e, input string tag);
    imem_ready = ir;
    dmem_ready = dr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
`ifdef CTRL_PERF_EN
    exp_instr += e.pc_en;
    if ((e.imem_ren && !ir) || ((e.dmem_ren || e.dmem_wen) && !dr)) exp_stall++;
`endif
    @(posedge CLK);
    #1;
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // Reference behaviour of one instruction, phase by phase.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wi, input int wd, input string tag, input bit rst_mid);
    obs_t e;
    bit rt, is_jr, is_j, is_jal, is_beq, is_bne, is_ld, is_st, wr;
    rt = (op == 6'h00);
    is_jr = rt && fn == 6'h08;
    is_j = op == 6'h02; is_jal = op == 6'h03;
    is_beq = op == 6'h04; is_bne = op == 6'h05;
    is_ld = op == 6'h23; is_st = op == 6'h2B;
    wr = (rt && !is_jr) || (op >= 6'h08 && op <= 6'h0F) || is_ld || is_jal;
    opcode = op; funct = fn; zero = z;

    for (int i = 0; i < wi; i++) begin
      e = idle(); e.imem_ren = 1;
      drive(1'b0, rb(), e, {tag, "_fw"});
    end
    e = idle(); e.imem_ren = 1; e.ir_en = 1;
    drive(1'b1, rb(), e, {tag, "_f"});
    e = idle();
    drive(rb(), rb(), e, {tag, "_d"});

    if (op == 6'h3F) begin
      for (int i = 0; i < 21; i++) begin
        e = idle(); e.halt = 1;
        zero = rb();
        drive(rb(), rb(), e, {tag, "_halted"});
      end
      return;
    end

    e = idle();
    if (rt && (fn == 6'h00 || fn == 6'h02)) e.alub_sel = AB_SHAMT;
    else if (rt || is_beq || is_bne)        e.alub_sel = AB_RF;
    else                                    e.alub_sel = AB_EXT32;
    if (is_j)  begin e.pc_sel = PC_JUMP; e.pc_en = 1; end
    if (is_jr) begin e.pc_sel = PC_JRA;  e.pc_en = 1; end
    if (is_beq || is_bne) begin
      e.pc_en = 1;
      e.pc_sel = ((is_beq && z) || (is_bne && !z)) ? PC_BRANCH : PC_NPC;
    end
    drive(rb(), rb(), e, {tag, "_x"});
    if (is_j || is_jr || is_beq || is_bne) return;

    if (is_ld || is_st) begin
      if (rst_mid) begin
        for (int i = 0; i < 2; i++) begin
          e = idle(); e.dmem_wen = is_st; e.dmem_ren = is_ld;
          drive(rb(), 1'b0, e, {tag, "_mw"});
        end
        dmem_ready = 1'b0;
        #2;
        chk("rst_pre_wen", {31'd0, dmem_wen}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("rst_async_out", {19'd0, act_v}, {19'd0, 13'(idle())});
`ifdef CTRL_PERF_EN
        exp_instr = 0; exp_stall = 0;
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        @(posedge CLK);
        #1;
        chk("rst_hold_out", {19'd0, act_v}, {19'd0, 13'(idle())});
        nRST = 1'b1;
        #1;
        chk("rst_release_fetch", {31'd0, imem_ren}, 32'd1);
        return;
      end
      for (int i = 0; i < wd; i++) begin
        e = idle(); e.dmem_ren = is_ld; e.dmem_wen = is_st;
        drive(rb(), 1'b0, e, {tag, "_mw"});
      end
      e = idle(); e.dmem_ren = is_ld; e.dmem_wen = is_st; e.pc_en = is_st;
      drive(rb(), 1'b1, e, {tag, "_m"});
      if (is_st) return;
    end

    e = idle();
    e.pc_en = 1;
    e.rf_wen = wr;
    e.pc_sel = is_jal ? PC_JUMP : PC_NPC;
    if (is_ld)            e.rfw_sel = RFW_RAMDATA;
    else if (op == 6'h0F) e.rfw_sel = RFW_IMM16;
    else if (is_jal)      e.rfw_sel = RFW_NPC;
    else                  e.rfw_sel = RFW_ALUO;
    drive(rb(), rb(), e, {tag, "_wb"});
  endtask

  logic [5:0] ops [0:15] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C,
                             6'h0F, 6'h23, 6'h2B, 6'h01, 6'h06, 6'h10, 6'h3E, 6'h0A};
  logic [5:0] fns [0:6]  = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h22, 6'h25, 6'h2A};

  task automatic run_random(input int n);
    logic [5:0] op, fn;
    for (int i = 0; i < n; i++) begin
      op = ops[$urandom_range(0, 15)];
      fn = fns[$urandom_range(0, 6)];
      run_instr(op, fn, rb(), $urandom_range(0, 3), $urandom_range(0, 3),
                $sformatf("rnd%0d_op%02h_fn%02h", i, op, fn), 1'b0);
    end
  endtask

  initial begin
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    opcode = 6'h08;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_out", {19'd0, act_v}, {19'd0, 13'(idle())});
`ifdef CTRL_PERF_EN
    chk("reset_instr_cnt", instr_cnt, 32'd0);
    chk("reset_stall_cnt", stall_cnt, 32'd0);
`endif
    nRST = 1'b1;

    run_instr(6'h08, 6'h00, 1'b0, 0, 0, "addi", 1'b0);
    run_instr(6'h23, 6'h00, 1'b0, 0, 3, "lw_wait3", 1'b0);
    run_instr(6'h04, 6'h00, 1'b1, 1, 0, "beq_taken", 1'b0);
    run_instr(6'h05, 6'h00, 1'b1, 0, 0, "bne_nt", 1'b0);
    run_instr(6'h05, 6'h00, 1'b0, 0, 0, "bne_taken", 1'b0);
    run_instr(6'h03, 6'h00, 1'b0, 2, 0, "jal", 1'b0);
    run_instr(6'h00, 6'h08, 1'b0, 0, 0, "jr", 1'b0);
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, "j", 1'b0);
    run_instr(6'h2B, 6'h00, 1'b0, 0, 1, "sw", 1'b0);
    run_instr(6'h0F, 6'h00, 1'b0, 0, 0, "lui", 1'b0);
    run_instr(6'h00, 6'h00, 1'b0, 0, 0, "sll", 1'b0);
    run_instr(6'h00, 6'h20, 1'b0, 0, 0, "add", 1'b0);
    run_instr(6'h01, 6'h00, 1'b0, 0, 0, "undef", 1'b0);
    run_random(40);
    run_instr(6'h2B, 6'h00, 1'b0, 0, 5, "sw_rst", 1'b1);
    run_random(10);
    run_instr(6'h3F, 6'h00, 1'b0, 1, 0, "halt", 1'b0);

    #10;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
`ifdef CTRL_PERF_EN
    chk("instr_cnt", instr_cnt, exp_instr);
    chk("stall_cnt", stall_cnt, exp_stall);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
